// File: rtl/fifo_pkg.sv
// Shared definitions for the fall-through FIFO: output-stage state encoding
// and the occupancy counter width, which must hold DEPTH+1.
package fifo_pkg;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_VALID = 1'b1;

  function automatic int count_width(input int depth_bits);
    return depth_bits + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_sync.sv
// Simple dual-port storage, one write and one registered read per cycle.
// Read data appears on the edge after the read is requested.
module fifo_ram_sync #(
  parameter int WIDTH     = 72,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fallthrough_fifo_v3.sv
// Fall-through FIFO: circular storage plus one-word head stage, 2-cycle first-word latency;
// writes at full are dropped, reads at empty ignored (sticky flags with FALLTHROUGH_FIFO_ERR_CHECK_EN).
module fallthrough_fifo_v3
  import fifo_pkg::*;
#(
  parameter int WIDTH                = 72,
  parameter int DEPTH_BITS           = 3,
  parameter int PROG_FULL_THRESHOLD  = (1 << DEPTH_BITS) - 1,
  parameter int PROG_EMPTY_THRESHOLD = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [WIDTH-1:0]                    din,
  input  logic                                wr_en,
  input  logic                                rd_en,
  output logic [WIDTH-1:0]                    dout,
  output logic                                empty,
  output logic                                full,
  output logic                                nearly_full,
  output logic                                prog_full,
  output logic                                prog_empty,
  output logic [count_width(DEPTH_BITS)-1:0]  count,
  input  logic                                clr_err,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int CW    = count_width(DEPTH_BITS);

  logic [DEPTH_BITS-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         stored, stored_next;
  logic [CW-1:0]         ready_words, ready_next;
  logic [CW-1:0]         count_next;
  logic [0:0]            state, state_next;
  logic                  wrote_last, wr_ok, pop;

  // A word becomes poppable one cycle after it is written, so the read
  // address never chases a same-edge write; this sets the 2-cycle latency.
  assign wr_ok = wr_en & ~full;
  assign pop   = ((state == ST_EMPTY) | rd_en) & (ready_words != '0);
  assign empty = (state == ST_EMPTY);

  always_comb begin
    state_next = state;
    if (pop)        state_next = ST_VALID;
    else if (rd_en) state_next = ST_EMPTY;
    stored_next = stored + CW'(wr_ok) - CW'(pop);
    ready_next  = ready_words + CW'(wrote_last) - CW'(pop);
    count_next  = stored_next + CW'(state_next == ST_VALID);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_EMPTY;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      stored      <= '0;
      ready_words <= '0;
      wrote_last  <= 1'b0;
      count       <= '0;
      full        <= 1'b0;
      nearly_full <= 1'b0;
      prog_full   <= 1'b0;
      prog_empty  <= 1'b1;
    end else begin
      state       <= state_next;
      if (wr_ok) wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      if (pop)   rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      stored      <= stored_next;
      ready_words <= ready_next;
      wrote_last  <= wr_ok;
      count       <= count_next;
      full        <= (stored_next == CW'(DEPTH));
      nearly_full <= (stored_next >= CW'(DEPTH - 1));
      prog_full   <= (count_next >= CW'(PROG_FULL_THRESHOLD));
      prog_empty  <= (count_next <= CW'(PROG_EMPTY_THRESHOLD));
    end
  end

  fifo_ram_sync #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (DEPTH_BITS)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (dout)
  );

`ifdef FALLTHROUGH_FIFO_ERR_CHECK_EN
  // A new error event wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_en & full)  | (overflow  & ~clr_err);
      underflow <= (rd_en & empty) | (underflow & ~clr_err);
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_err;
  assign overflow   = 1'b0;
  assign underflow  = 1'b0;
`endif

endmodule

// File: tb/tb_fallthrough_fifo_v3.sv
// Bench for fallthrough_fifo_v3: queue-based reference checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fallthrough_fifo_v3;

  localparam int W     = 32;
  localparam int DB    = 3;
  localparam int DEPTH = 8;
`ifdef FALLTHROUGH_FIFO_ERR_CHECK_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, wr_en, rd_en, clr_err;
  logic [W-1:0]  din, dout;
  logic          empty, full, nearly_full, prog_full, prog_empty;
  logic [DB:0]   count;
  logic          overflow, underflow;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fallthrough_fifo_v3 #(
    .WIDTH(W), .DEPTH_BITS(DB), .PROG_FULL_THRESHOLD(6), .PROG_EMPTY_THRESHOLD(1)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .empty(empty), .full(full), .nearly_full(nearly_full),
    .prog_full(prog_full), .prog_empty(prog_empty), .count(count),
    .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: storage queue with write timestamps, a head register, sticky flags.
  logic [W-1:0] m_q[$];
  int           m_t[$];
  logic [W-1:0] m_head;
  bit           m_valid;
  bit           m_ovf, m_udf;
  int           cyc = 0;

  always @(posedge clk) begin
    bit acc, ovf_ev, udf_ev;
    cyc++;
    if (reset) begin
      m_q.delete(); m_t.delete();
      m_valid = 0; m_ovf = 0; m_udf = 0;
    end else begin
      acc    = wr_en && (m_q.size() < DEPTH);
      ovf_ev = wr_en && !acc;
      udf_ev = rd_en && !m_valid;
      if (!m_valid || rd_en) begin
        // a stored word may move to the head two edges after being written
        if (m_q.size() > 0 && m_t[0] <= cyc - 2) begin
          m_head  = m_q.pop_front();
          void'(m_t.pop_front());
          m_valid = 1;
        end else begin
          m_valid = 0;
        end
      end
      if (acc) begin
        m_q.push_back(din);
        m_t.push_back(cyc);
      end
      m_ovf = ERR && (ovf_ev || (m_ovf && !clr_err));
      m_udf = ERR && (udf_ev || (m_udf && !clr_err));
    end
  end

  always @(posedge clk) begin
    int occ;
    #1;
    occ = m_q.size() + int'(m_valid);
    check("m_empty",       64'(empty),       64'(!m_valid));
    check("m_count",       64'(count),       64'(occ));
    check("m_full",        64'(full),        64'(m_q.size() == DEPTH));
    check("m_nearly_full", 64'(nearly_full), 64'(m_q.size() >= DEPTH - 1));
    check("m_prog_full",   64'(prog_full),   64'(occ >= 6));
    check("m_prog_empty",  64'(prog_empty),  64'(occ <= 1));
    check("m_overflow",    64'(overflow),    64'(m_ovf));
    check("m_underflow",   64'(underflow),   64'(m_udf));
    if (m_valid) check("m_dout", 64'(dout), 64'(m_head));
  end

  task automatic step(input logic r, input logic w, input logic [W-1:0] d,
                      input logic rd, input logic c);
    @(negedge clk);
    reset = r; wr_en = w; din = d; rd_en = rd; clr_err = c;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic fill9();
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) step(1'b0, 1'b1, W'(i), 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_nfull", 64'(nearly_full), 64'd0);
    check("rst_pfull", 64'(prog_full), 64'd0);
    check("rst_pempty", 64'(prog_empty), 64'd1);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_udf", 64'(underflow), 64'd0);

    // first-word latency
    step(1'b0, 1'b1, 32'h1, 1'b0, 1'b0);
    check("lat_n0_empty", 64'(empty), 64'd1);
    idle(1);
    check("lat_n1_empty", 64'(empty), 64'd1);
    idle(1);
    check("lat_n2_empty", 64'(empty), 64'd0);
    check("lat_n2_dout", 64'(dout), 64'h1);
    check("lat_n2_count", 64'(count), 64'd1);

    // fill to capacity, then one dropped write
    fill9();
    check("fill_count", 64'(count), 64'd9);
    check("fill_full", 64'(full), 64'd1);
    check("fill_pfull", 64'(prog_full), 64'd1);
    step(1'b0, 1'b1, 32'hA, 1'b0, 1'b0);
    check("ovf_count", 64'(count), 64'd9);
    check("ovf_flag", 64'(overflow), 64'(ERR));
    idle(1);

    // drain in order, then one read too many
    for (int i = 1; i <= 9; i++) begin
      check("drain_dout", 64'(dout), 64'(i));
      step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    end
    check("drain_empty", 64'(empty), 64'd1);
    check("drain_count", 64'(count), 64'd0);
    check("drain_pempty", 64'(prog_empty), 64'd1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("udf_flag", 64'(underflow), 64'(ERR));
    check("udf_count", 64'(count), 64'd0);

    // error clear, and set-beats-clear
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("clr_ovf", 64'(overflow), 64'd0);
    check("clr_udf", 64'(underflow), 64'd0);
    fill9();
    step(1'b0, 1'b1, 32'hB, 1'b0, 1'b1);
    check("setclr_ovf", 64'(overflow), 64'(ERR));
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("clr2_ovf", 64'(overflow), 64'd0);

    // sustained read+write at count 3 across pointer wrap
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h100 + W'(i), 1'b0, 1'b0);
    idle(2);
    check("stream_pre_count", 64'(count), 64'd3);
    check("stream_pre_dout", 64'(dout), 64'h100);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 32'h103 + W'(i), 1'b1, 1'b0);
      check("stream_count", 64'(count), 64'd3);
      check("stream_dout", 64'(dout), 64'(32'h101 + W'(i)));
    end
    check("stream_end_empty", 64'(empty), 64'd0);

    // reset mid-operation with requests asserted
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h200 + W'(i), 1'b0, 1'b0);
    check("mid_count", 64'(count), 64'd5);
    step(1'b1, 1'b1, 32'hDEAD, 1'b1, 1'b0);
    check("mid_rst_empty", 64'(empty), 64'd1);
    check("mid_rst_count", 64'(count), 64'd0);
    check("mid_rst_full", 64'(full), 64'd0);
    step(1'b0, 1'b1, 32'h55, 1'b0, 1'b0);
    idle(2);
    check("post_rst_dout", 64'(dout), 64'h55);
    check("post_rst_empty", 64'(empty), 64'd0);
    check("post_rst_count", 64'(count), 64'd1);

    idle(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fallthrough_fifo_v3.md
FALLTHROUGH_FIFO_V3 -- requirements
Module: fallthrough_fifo_v3

Interface
REQ-001 SHALL have parameter WIDTH, default 72, data word width in bits.
REQ-002 SHALL have parameter DEPTH_BITS, default 3, storage depth = 2**DEPTH_BITS words (DEPTH); legal range 2..10.
REQ-003 SHALL have parameter PROG_FULL_THRESHOLD, default DEPTH-1, occupancy at or above which prog_full asserts.
REQ-004 SHALL have parameter PROG_EMPTY_THRESHOLD, default 1, occupancy at or below which prog_empty asserts.
REQ-005 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port din, input, WIDTH, write data.
REQ-008 SHALL have port wr_en, input, 1, write request.
REQ-009 SHALL have port rd_en, input, 1, pop current head word.
REQ-010 SHALL have port dout, output, WIDTH, head word, valid whenever empty=0.
REQ-011 SHALL have port empty, output, 1, registered; 0 = dout valid.
REQ-012 SHALL have ports full, nearly_full, prog_full, prog_empty, outputs, 1 bit each, status flags.
REQ-013 SHALL have port count, output, DEPTH_BITS+1, total occupancy (storage plus output stage).
REQ-014 SHALL have ports clr_err input 1, overflow output 1, underflow output 1, sticky error flags.

Function
REQ-015 Storage SHALL be a DEPTH-word circular buffer with wrapping read/write pointers, followed by a one-word output stage.
REQ-016 Output stage FSM SHALL have states EMPTY and VALID; empty=1 exactly in EMPTY.
REQ-017 In EMPTY with storage non-empty, FSM SHALL pop storage and enter VALID next cycle.
REQ-018 In VALID with rd_en=1: storage non-empty -> pop storage, stay VALID, new head next cycle; storage empty -> enter EMPTY.
REQ-019 First-word latency SHALL be 2 cycles: write accepted at edge N into an idle FIFO -> empty=0 and dout=din after edge N+2.
REQ-020 Sustained rd_en=1 and wr_en=1 in VALID SHALL give one word per cycle, no bubbles.
REQ-021 full SHALL be 1 when storage holds DEPTH words; nearly_full when storage holds >= DEPTH-1.
REQ-022 A write SHALL be accepted iff wr_en=1 and full=0 in that cycle; a same-cycle read does not unblock a write at full (no rd_en-to-full combinational path).
REQ-023 A write with full=1 SHALL be discarded, storage unchanged.
REQ-024 rd_en=1 with empty=1 SHALL be ignored, no state change.
REQ-025 count SHALL equal stored words plus 1 when VALID; maximum DEPTH+1; updated on the same edge as the write/pop; simultaneous accepted write and pop leaves count unchanged.
REQ-026 prog_full SHALL be count >= PROG_FULL_THRESHOLD; prog_empty SHALL be count <= PROG_EMPTY_THRESHOLD; both registered.
REQ-027 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated words.

Reset
REQ-028 On reset: FSM = EMPTY, pointers = 0, count = 0, empty=1, full=0, nearly_full=0, prog_full=0, prog_empty=1, overflow=0, underflow=0; dout undefined.
REQ-029 Reset mid-operation SHALL discard all contents within one cycle; wr_en/rd_en in the reset cycle are ignored.

Configuration
REQ-030 Macro FALLTHROUGH_FIFO_ERR_CHECK_EN defined: overflow sets on a discarded write (REQ-023), underflow sets on an ignored read (REQ-024), both hold until clr_err=1 or reset; a set event coincident with clr_err takes priority (flag = 1).
REQ-031 Macro undefined: overflow and underflow tied to 0, clr_err unused, no error logic synthesized; all other behaviour identical.

Structure
REQ-032 Shared package fifo_pkg SHALL hold FSM state encoding (EMPTY/VALID) and the function computing count width from DEPTH_BITS.
REQ-033 Storage SHALL be sub-module fifo_ram_sync (simple dual-port, registered read, WIDTH x DEPTH); control and flags stay in the top.

Verification (DEPTH_BITS=3, WIDTH=32, PROG_FULL_THRESHOLD=6, PROG_EMPTY_THRESHOLD=1)
REQ-034 Reset, write 0x1 at edge N -> empty=0, dout=0x1 after edge N+2; count=1.
REQ-035 Write 0x1..0x9 with no reads -> all accepted (8 storage + 1 output), full=1, count=9, prog_full=1; 10th write 0xA dropped, overflow=1 (macro on).
REQ-036 From full, 9 consecutive reads -> dout 0x1..0x9 in order, empty=1 after 9th, prog_empty=1; 10th read -> underflow=1, count stays 0.
REQ-037 20 cycles simultaneous wr_en/rd_en with count=3, incrementing data -> count stays 3, outputs strictly sequential across pointer wrap.
REQ-038 Assert reset with count=5 -> next cycle empty=1, count=0, full=0; write 0x55 -> dout=0x55 two cycles later.
REQ-039 Set overflow, pulse clr_err -> overflow=0 next cycle; repeat with overflowing write coincident with clr_err -> overflow=1.
